// File: rtl/blockd_stream_router.sv
// Stream router: one rdy/vld input fanned out to N_CH FWFT channel FIFOs by
// destination, round-robin or broadcast, with a req/ack flush handshake.
module blockd_stream_router #(
    parameter int N_CH  = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int DSTW  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [1:0]                         mode,
    input  logic                               in_vld,
    output logic                               in_rdy,
    input  logic [DW-1:0]                      in_data,
    input  logic [DSTW-1:0]                    in_dest,
    output logic [N_CH-1:0]                    out_vld,
    input  logic [N_CH-1:0]                    out_rdy,
    output logic [N_CH*DW-1:0]                 out_data,
    input  logic                               flush_req,
    output logic                               flush_ack,
    output logic [N_CH*$clog2(DEPTH+1)-1:0]    occ,
    output logic [15:0]                        drop_cnt
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(N_CH);
    localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [15:0]     drops;
    logic [N_CH-1:0] full, nonempty, tgt, push, pop;
    logic            rdy, drop, accept, all_empty;

    assign all_empty = ~|nonempty;

    // Target selection; readiness looks only at registered fullness, never at a same-cycle pop.
    always_comb begin
        tgt  = '0;
        rdy  = 1'b0;
        drop = 1'b0;
        if (!rst && state == IDLE) begin
            case (mode)
                2'd0: begin
                    if (int'(in_dest) < N_CH) begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (in_dest == DSTW'(i)) begin
                                tgt[i] = 1'b1;
                                rdy    = !full[i];
                            end
                        end
                    end else begin
                        rdy  = 1'b1;
                        drop = 1'b1;
                    end
                end
                2'd1: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (rr_ptr == PW'(i)) begin
                            tgt[i] = 1'b1;
                            rdy    = !full[i];
                        end
                    end
                end
                2'd2: begin
                    tgt = '1;
                    rdy = ~|full;
                end
                default: ;
            endcase
        end
    end

    assign in_rdy = rdy;
    assign accept = in_vld & rdy;
    assign push   = tgt & {N_CH{accept}};
    assign pop    = nonempty & out_rdy;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DW-1:0] mem [DEPTH];
        logic [AW-1:0] rd_ptr, wr_ptr;
        logic [OW-1:0] count;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[g]) begin
                    mem[wr_ptr] <= in_data;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push[g] && !pop[g]) begin
                    count <= count + 1'b1;
                end else if (!push[g] && pop[g]) begin
                    count <= count - 1'b1;
                end
            end
        end

        assign full[g]               = (count == FULL_CNT);
        assign nonempty[g]           = (count != '0);
        assign out_vld[g]            = nonempty[g];
        assign out_data[g*DW +: DW]  = mem[rd_ptr];
        assign occ[g*OW +: OW]       = count;
    end

    // The RR pointer only moves on RR accepts, so it survives excursions into other modes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            drops  <= '0;
        end else begin
            if (accept && mode == 2'd1) begin
                rr_ptr <= (rr_ptr == PTR_LAST) ? '0 : rr_ptr + 1'b1;
            end
            if (accept && drop && drops != 16'hFFFF) begin
                drops <= drops + 1'b1;
            end
        end
    end

    assign drop_cnt = drops;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (flush_req) state_nxt = DRAIN;
            DRAIN:   if (all_empty) state_nxt = ACK;
            ACK:     if (!flush_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign flush_ack = (state == ACK);

endmodule

// File: tb/tb_blockd_stream_router.sv
// Self-checking bench for blockd_stream_router: vector table, queue-based
// random reference model, and hand-written backpressure/broadcast/flush/saturation sequences.
module tb_blockd_stream_router;

    localparam int N_CH  = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int DSTW  = 4;
    localparam int OW    = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           mode;
    logic                 in_vld;
    logic                 in_rdy;
    logic [DW-1:0]        in_data;
    logic [DSTW-1:0]      in_dest;
    logic [N_CH-1:0]      out_vld;
    logic [N_CH-1:0]      out_rdy;
    logic [N_CH*DW-1:0]   out_data;
    logic                 flush_req;
    logic                 flush_ack;
    logic [N_CH*OW-1:0]   occ;
    logic [15:0]          drop_cnt;

    int tests    = 0;
    int failures = 0;

    blockd_stream_router #(.N_CH(N_CH), .DW(DW), .DEPTH(DEPTH), .DSTW(DSTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .flush_req (flush_req),
        .flush_ack (flush_ack),
        .occ       (occ),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        vld;
        logic [31:0] data;
        logic [3:0]  dest;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_vld;
        logic [11:0] exp_occ;
        logic [15:0] exp_drop;
        logic [1:0]  chk;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[22];

    logic [31:0] mq [N_CH][$];
    int          m_ptr;
    int          m_drops;

    logic [1:0]  cur_mode;
    logic        cur_vld;
    logic [31:0] cur_data;
    logic [3:0]  cur_dest;
    logic [3:0]  cur_ordy;
    logic        exp_rdy;
    logic        stalled;
    logic [3:0]  exp_vld;
    logic [11:0] exp_occ;

    task automatic applyStimulus(input logic [1:0] m, input logic v, input logic [31:0] d,
                                 input logic [3:0] ds, input logic [3:0] ordy, input logic fr);
        mode      = m;
        in_vld    = v;
        in_data   = d;
        in_dest   = ds;
        out_rdy   = ordy;
        flush_req = fr;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dataOf(int ch);
        return out_data[ch*DW +: DW];
    endfunction

    function automatic logic [2:0] occOf(int ch);
        return occ[ch*OW +: OW];
    endfunction

    function automatic logic modelReady(logic [1:0] m, logic [3:0] d);
        logic r;
        r = 1'b1;
        case (m)
            2'd0: if (int'(d) < N_CH) r = (mq[int'(d)].size() < DEPTH);
            2'd1: r = (mq[m_ptr].size() < DEPTH);
            2'd2: for (int i = 0; i < N_CH; i++) if (mq[i].size() >= DEPTH) r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(2'd0, 1'b1, 32'h0, 4'd0, 4'hF, 1'b0);
        @(negedge clk);
        checkOutput("reset in_rdy", in_rdy, 1'b0);
        tick();
        in_vld = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset out_vld", out_vld, 4'h0);
        checkOutput("reset occ", occ, 12'h0);
        checkOutput("reset drop_cnt", drop_cnt, 16'h0);
        checkOutput("reset flush_ack", flush_ack, 1'b0);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // mode, vld, data, dest, out_rdy | in_rdy, out_vld, occ, drop_cnt, checked ch, data
        vecs[0]  = '{2'd0, 1'b1, 32'hA0, 4'd0, 4'hF, 1'b1, 4'h0, 12'h000, 16'd0, 2'd0, 32'h0};
        vecs[1]  = '{2'd0, 1'b1, 32'hA1, 4'd1, 4'hF, 1'b1, 4'h1, 12'h001, 16'd0, 2'd0, 32'hA0};
        vecs[2]  = '{2'd0, 1'b1, 32'hA2, 4'd2, 4'hF, 1'b1, 4'h2, 12'h008, 16'd0, 2'd1, 32'hA1};
        vecs[3]  = '{2'd0, 1'b1, 32'hA3, 4'd3, 4'hF, 1'b1, 4'h4, 12'h040, 16'd0, 2'd2, 32'hA2};
        vecs[4]  = '{2'd0, 1'b0, 32'h00, 4'd0, 4'hF, 1'b1, 4'h8, 12'h200, 16'd0, 2'd3, 32'hA3};
        vecs[5]  = '{2'd0, 1'b0, 32'h00, 4'd0, 4'hF, 1'b1, 4'h0, 12'h000, 16'd0, 2'd0, 32'h0};
        vecs[6]  = '{2'd0, 1'b1, 32'hDD, 4'd7, 4'hF, 1'b1, 4'h0, 12'h000, 16'd0, 2'd0, 32'h0};
        vecs[7]  = '{2'd0, 1'b1, 32'hDD, 4'd7, 4'hF, 1'b1, 4'h0, 12'h000, 16'd1, 2'd0, 32'h0};
        vecs[8]  = '{2'd0, 1'b1, 32'hDD, 4'd7, 4'hF, 1'b1, 4'h0, 12'h000, 16'd2, 2'd0, 32'h0};
        vecs[9]  = '{2'd0, 1'b0, 32'h00, 4'd7, 4'hF, 1'b1, 4'h0, 12'h000, 16'd3, 2'd0, 32'h0};
        vecs[10] = '{2'd1, 1'b1, 32'hB0, 4'd0, 4'hF, 1'b1, 4'h0, 12'h000, 16'd3, 2'd0, 32'h0};
        vecs[11] = '{2'd1, 1'b1, 32'hB1, 4'd0, 4'hF, 1'b1, 4'h1, 12'h001, 16'd3, 2'd0, 32'hB0};
        vecs[12] = '{2'd1, 1'b1, 32'hB2, 4'd0, 4'hF, 1'b1, 4'h2, 12'h008, 16'd3, 2'd1, 32'hB1};
        vecs[13] = '{2'd1, 1'b1, 32'hB3, 4'd0, 4'hF, 1'b1, 4'h4, 12'h040, 16'd3, 2'd2, 32'hB2};
        vecs[14] = '{2'd1, 1'b1, 32'hB4, 4'd0, 4'hF, 1'b1, 4'h8, 12'h200, 16'd3, 2'd3, 32'hB3};
        vecs[15] = '{2'd1, 1'b1, 32'hB5, 4'd0, 4'hF, 1'b1, 4'h1, 12'h001, 16'd3, 2'd0, 32'hB4};
        vecs[16] = '{2'd1, 1'b0, 32'h00, 4'd0, 4'hF, 1'b1, 4'h2, 12'h008, 16'd3, 2'd1, 32'hB5};
        vecs[17] = '{2'd3, 1'b1, 32'hC0, 4'd0, 4'hF, 1'b0, 4'h0, 12'h000, 16'd3, 2'd0, 32'h0};
        vecs[18] = '{2'd2, 1'b1, 32'hC1, 4'd0, 4'h0, 1'b1, 4'h0, 12'h000, 16'd3, 2'd0, 32'h0};
        vecs[19] = '{2'd2, 1'b0, 32'h00, 4'd0, 4'h0, 1'b1, 4'hF, 12'h249, 16'd3, 2'd2, 32'hC1};
        vecs[20] = '{2'd0, 1'b0, 32'h00, 4'd0, 4'hF, 1'b1, 4'hF, 12'h249, 16'd3, 2'd3, 32'hC1};
        vecs[21] = '{2'd0, 1'b0, 32'h00, 4'd0, 4'hF, 1'b1, 4'h0, 12'h000, 16'd3, 2'd0, 32'h0};

        doReset();
        for (int r = 0; r < 22; r++) begin
            applyStimulus(vecs[r].mode, vecs[r].vld, vecs[r].data, vecs[r].dest, vecs[r].ordy, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d in_rdy", r), in_rdy, vecs[r].exp_rdy);
            checkOutput($sformatf("vec%0d out_vld", r), out_vld, vecs[r].exp_vld);
            checkOutput($sformatf("vec%0d occ", r), occ, vecs[r].exp_occ);
            checkOutput($sformatf("vec%0d drop_cnt", r), drop_cnt, vecs[r].exp_drop);
            if (vecs[r].exp_vld[vecs[r].chk])
                checkOutput($sformatf("vec%0d data", r), dataOf(int'(vecs[r].chk)), vecs[r].exp_data);
            tick();
        end

        // Random traffic against a queue model; the reset before it must also clear the RR pointer.
        doReset();
        m_ptr   = 0;
        m_drops = 0;
        for (int i = 0; i < N_CH; i++) mq[i].delete();
        stalled = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!stalled) begin
                int r;
                r        = int'($urandom_range(0, 9));
                cur_mode = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
                cur_dest = 4'($urandom_range(0, 5));
                cur_data = $urandom;
                cur_vld  = ($urandom_range(0, 3) != 0);
            end
            cur_ordy = 4'($urandom_range(0, 15));
            applyStimulus(cur_mode, cur_vld, cur_data, cur_dest, cur_ordy, 1'b0);
            exp_rdy = modelReady(cur_mode, cur_dest);
            for (int i = 0; i < N_CH; i++) begin
                exp_vld[i]          = (mq[i].size() > 0);
                exp_occ[i*OW +: OW] = 3'(mq[i].size());
            end
            @(negedge clk);
            checkOutput("rnd in_rdy", in_rdy, exp_rdy);
            checkOutput("rnd out_vld", out_vld, exp_vld);
            checkOutput("rnd occ", occ, exp_occ);
            checkOutput("rnd drop_cnt", drop_cnt, 16'(m_drops));
            for (int i = 0; i < N_CH; i++)
                if (mq[i].size() > 0) checkOutput($sformatf("rnd data ch%0d", i), dataOf(i), mq[i][0]);
            stalled = cur_vld && !exp_rdy && (cur_mode != 2'd3);
            for (int i = 0; i < N_CH; i++)
                if (mq[i].size() > 0 && cur_ordy[i]) void'(mq[i].pop_front());
            if (cur_vld && exp_rdy) begin
                case (cur_mode)
                    2'd0: begin
                        if (int'(cur_dest) < N_CH) mq[int'(cur_dest)].push_back(cur_data);
                        else if (m_drops < 65535) m_drops++;
                    end
                    2'd1: begin
                        mq[m_ptr].push_back(cur_data);
                        m_ptr = (m_ptr + 1) % N_CH;
                    end
                    2'd2: for (int i = 0; i < N_CH; i++) mq[i].push_back(cur_data);
                    default: ;
                endcase
            end
            tick();
        end

        // Backpressure on channel 2: four fit, fifth waits, order kept.
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'd0, 1'b1, 32'hD1 + k, 4'd2, 4'b1011, 1'b0);
            @(negedge clk);
            checkOutput("bp accept", in_rdy, 1'b1);
            tick();
        end
        applyStimulus(2'd0, 1'b1, 32'hD5, 4'd2, 4'b1011, 1'b0);
        @(negedge clk);
        checkOutput("bp full in_rdy", in_rdy, 1'b0);
        checkOutput("bp full occ", occOf(2), 3'd4);
        checkOutput("bp head", dataOf(2), 32'hD1);
        tick();
        applyStimulus(2'd0, 1'b1, 32'hD5, 4'd2, 4'b1111, 1'b0);
        @(negedge clk);
        checkOutput("bp no pop bypass", in_rdy, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("bp reopen", in_rdy, 1'b1);
        checkOutput("bp occ 3", occOf(2), 3'd3);
        checkOutput("bp d2", dataOf(2), 32'hD2);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'd0, 1'b0, 32'h0, 4'd2, 4'b1111, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("bp order %0d", k), dataOf(2), 32'hD3 + k);
            checkOutput("bp vld", out_vld[2], 1'b1);
            tick();
        end
        @(negedge clk);
        checkOutput("bp empty", occ, 12'h0);
        tick();

        // Broadcast blocked by one full channel, then lands everywhere at once.
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'd0, 1'b1, 32'hF1 + k, 4'd1, 4'b1101, 1'b0);
            tick();
        end
        applyStimulus(2'd2, 1'b1, 32'hE0, 4'd0, 4'b1101, 1'b0);
        @(negedge clk);
        checkOutput("bc blocked", in_rdy, 1'b0);
        checkOutput("bc ch1 full", occOf(1), 3'd4);
        tick();
        applyStimulus(2'd2, 1'b1, 32'hE0, 4'd0, 4'b1111, 1'b0);
        @(negedge clk);
        checkOutput("bc still blocked", in_rdy, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("bc open", in_rdy, 1'b1);
        tick();
        applyStimulus(2'd0, 1'b0, 32'h0, 4'd0, 4'b1111, 1'b0);
        @(negedge clk);
        checkOutput("bc out_vld", out_vld, 4'hF);
        checkOutput("bc ch0", dataOf(0), 32'hE0);
        checkOutput("bc ch2", dataOf(2), 32'hE0);
        checkOutput("bc ch3", dataOf(3), 32'hE0);
        checkOutput("bc ch1 occ", occOf(1), 3'd3);
        checkOutput("bc ch1 head", dataOf(1), 32'hF3);
        tick();

        // Flush with three beats queued on channel 0.
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'd0, 1'b1, 32'h60 + k, 4'd0, 4'b0000, 1'b0);
            tick();
        end
        applyStimulus(2'd0, 1'b0, 32'h0, 4'd0, 4'b0000, 1'b1);
        @(negedge clk);
        checkOutput("fl idle ack", flush_ack, 1'b0);
        tick();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(2'd0, 1'b1, 32'h63, 4'd0, 4'b0001, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("fl drain in_rdy %0d", c), in_rdy, 1'b0);
            checkOutput($sformatf("fl drain ack %0d", c), flush_ack, 1'b0);
            if (c < 3) checkOutput($sformatf("fl drain data %0d", c), dataOf(0), 32'h60 + c);
            tick();
        end
        applyStimulus(2'd0, 1'b1, 32'h63, 4'd0, 4'b0001, 1'b0);
        @(negedge clk);
        checkOutput("fl ack", flush_ack, 1'b1);
        checkOutput("fl ack in_rdy", in_rdy, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("fl release ack", flush_ack, 1'b0);
        checkOutput("fl release in_rdy", in_rdy, 1'b1);
        tick();

        // flush_req dropped while draining still yields a one-cycle ack.
        doReset();
        applyStimulus(2'd0, 1'b1, 32'h77, 4'd0, 4'b0000, 1'b0);
        tick();
        applyStimulus(2'd0, 1'b0, 32'h0, 4'd0, 4'b0000, 1'b1);
        tick();
        applyStimulus(2'd0, 1'b0, 32'h0, 4'd0, 4'b0001, 1'b0);
        @(negedge clk);
        checkOutput("fl2 drain ack", flush_ack, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("fl2 empty ack", flush_ack, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("fl2 pulse", flush_ack, 1'b1);
        tick();
        @(negedge clk);
        checkOutput("fl2 after", flush_ack, 1'b0);
        tick();

        // Drop counter saturation.
        doReset();
        applyStimulus(2'd0, 1'b1, 32'h0, 4'd7, 4'hF, 1'b0);
        @(negedge clk);
        checkOutput("sat in_rdy", in_rdy, 1'b1);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        checkOutput("sat fffe", drop_cnt, 16'hFFFE);
        @(posedge clk);
        @(negedge clk);
        checkOutput("sat ffff", drop_cnt, 16'hFFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("sat hold", drop_cnt, 16'hFFFF);
        checkOutput("sat out_vld", out_vld, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
